// File: rtl/lc3_mem_arbiter_if.sv
// Shared memory-port bundle for lc3_mem_arbiter: CPU and DMA request channels plus the memory side.
// The master modport is the arbiter's view; the slave modport is the requesters' and memory's view.
interface lc3_mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rdy;

   logic          dma_req;
   logic          dma_we;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic [DW-1:0] dma_rdata;
   logic          dma_rdy;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   logic          grant_dma;
   logic          timeout_err;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_rdy,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_rdata, dma_rdy,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack,
      output grant_dma, timeout_err
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_rdy,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_rdata, dma_rdy,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack,
      input  grant_dma, timeout_err
   );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// CPU/DMA arbiter for the single LC-3 memory port: IDLE -> XFER -> RESP, one-cycle rdy to the winner.
// Optional XFER watchdog enabled by defining LC3_MEM_ARB_TIMEOUT_EN.
module lc3_mem_arbiter #(
   parameter int AW            = 16,
   parameter int DW            = 16,
   parameter int MAX_CPU_BURST = 4,
   parameter int TIMEOUT       = 255
) (
   input logic               clk,
   input logic               rst,
   lc3_mem_arbiter_if.master bus
);
   localparam int            SW        = $clog2(MAX_CPU_BURST + 1);
   localparam logic [SW-1:0] BURST_MAX = SW'(MAX_CPU_BURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [SW-1:0] streak_r;
   logic          any_req_s;
   logic          dma_win_s;
   logic          done_s;
   logic          abort_s;

   logic          mem_en_r;
   logic          mem_we_r;
   logic [AW-1:0] mem_addr_r;
   logic [DW-1:0] mem_wdata_r;
   logic          grant_r;
   logic [DW-1:0] cpu_rdata_r;
   logic [DW-1:0] dma_rdata_r;
   logic          cpu_rdy_r;
   logic          dma_rdy_r;
   logic          tmo_err_r;

`ifdef LC3_MEM_ARB_TIMEOUT_EN
   localparam int            TW       = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tmo_cnt_r;

   // XFER cycle counter; idles at zero so it is already clear on XFER entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (state_r != XFER) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (!bus.mem_ack) begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // The TIMEOUT-th XFER cycle without an ack ends the transfer
   assign abort_s = (state_r == XFER) && !bus.mem_ack && (tmo_cnt_r == TMO_LAST);
`else
   assign abort_s = 1'b0;
`endif

   // Winner selection and next-state decode
   always_comb begin
      state_s   = state_r;
      any_req_s = bus.cpu_req | bus.dma_req;
      dma_win_s = bus.dma_req & (~bus.cpu_req | (streak_r >= BURST_MAX));
      done_s    = (state_r == XFER) & bus.mem_ack;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_s = XFER;
            end else begin
               state_s = IDLE;
            end
         end
         XFER: begin
            if (done_s || abort_s) begin
               state_s = RESP;
            end else begin
               state_s = XFER;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Registered memory-side fields, grant status, streak counter and responses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {AW{1'b0}};
         mem_wdata_r <= {DW{1'b0}};
         grant_r     <= 1'b0;
         streak_r    <= {SW{1'b0}};
         cpu_rdata_r <= {DW{1'b0}};
         dma_rdata_r <= {DW{1'b0}};
         cpu_rdy_r   <= 1'b0;
         dma_rdy_r   <= 1'b0;
         tmo_err_r   <= 1'b0;
      end else begin
         cpu_rdy_r <= 1'b0;
         dma_rdy_r <= 1'b0;
         tmo_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  mem_en_r    <= 1'b1;
                  grant_r     <= dma_win_s;
                  mem_we_r    <= dma_win_s ? bus.dma_we    : bus.cpu_we;
                  mem_addr_r  <= dma_win_s ? bus.dma_addr  : bus.cpu_addr;
                  mem_wdata_r <= dma_win_s ? bus.dma_wdata : bus.cpu_wdata;
                  // Only CPU wins that starve a waiting DMA count toward the burst limit
                  if (dma_win_s || !bus.dma_req) begin
                     streak_r <= {SW{1'b0}};
                  end else if (streak_r < BURST_MAX) begin
                     streak_r <= streak_r + SW'(1);
                  end
               end
            end
            XFER: begin
               if (done_s || abort_s) begin
                  mem_en_r  <= 1'b0;
                  cpu_rdy_r <= ~grant_r;
                  dma_rdy_r <= grant_r;
                  tmo_err_r <= abort_s;
                  if (done_s && !mem_we_r) begin
                     if (grant_r) begin
                        dma_rdata_r <= bus.mem_rdata;
                     end else begin
                        cpu_rdata_r <= bus.mem_rdata;
                     end
                  end
               end
            end
            RESP: begin
               mem_en_r <= 1'b0;
            end
            default: begin
               mem_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_en      = mem_en_r;
   assign bus.mem_we      = mem_we_r;
   assign bus.mem_addr    = mem_addr_r;
   assign bus.mem_wdata   = mem_wdata_r;
   assign bus.grant_dma   = grant_r;
   assign bus.cpu_rdata   = cpu_rdata_r;
   assign bus.dma_rdata   = dma_rdata_r;
   assign bus.cpu_rdy     = cpu_rdy_r;
   assign bus.dma_rdy     = dma_rdy_r;
   assign bus.timeout_err = tmo_err_r;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed scoreboard bench for lc3_mem_arbiter: expected grants/responses are queued as
// requests are issued and checked by a monitor when grants and rdy pulses appear.
module tb_lc3_mem_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lc3_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   lc3_mem_arbiter #(.AW(AW), .DW(DW), .MAX_CPU_BURST(4), .TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        dma;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          lat;
      logic        tmo;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [15:0] mem_arr [logic [15:0]];
   int          ack_lat   = 1;
   int          mm_cnt    = 0;
   logic        stray_ack = 1'b0;
   logic [15:0] last_cpu_rd = 16'h0000;
   logic [15:0] last_dma_rd = 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected rdata: reads return rd, writes and timeouts keep the requester's last read value
   function automatic void sb_push(input logic dma, input logic we, input logic [15:0] addr,
                                   input logic [15:0] wdata, input logic [15:0] rd,
                                   input int lat, input logic tmo);
      exp_t e;
      if (!we && !tmo) begin
         if (dma) last_dma_rd = rd;
         else     last_cpu_rd = rd;
      end
      e.dma   = dma;
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      e.rdata = dma ? last_dma_rd : last_cpu_rd;
      e.lat   = lat;
      e.tmo   = tmo;
      sb.push_back(e);
   endfunction

   // Issue n back-to-back transactions from one requester; req stays high between them
   task automatic req_run(input logic dma, input int n, input logic we, input logic [15:0] base,
                          input logic [15:0] wd, output int cyc);
      logic seen;
      cyc = 0;
      if (dma) begin
         bus.dma_we = we; bus.dma_addr = base; bus.dma_wdata = wd; bus.dma_req = 1'b1;
      end else begin
         bus.cpu_we = we; bus.cpu_addr = base; bus.cpu_wdata = wd; bus.cpu_req = 1'b1;
      end
      for (int k = 0; k < n; k++) begin
         seen = 1'b0;
         for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            cyc++;
            seen = dma ? bus.dma_rdy : bus.cpu_rdy;
         end
         chk(dma ? "dma_rdy_wait" : "cpu_rdy_wait", 32'(seen), 32'd1);
         if (dma) bus.dma_addr = base + 16'(k + 1);
         else     bus.cpu_addr = base + 16'(k + 1);
      end
      if (dma) bus.dma_req = 1'b0;
      else     bus.cpu_req = 1'b0;
   endtask

   // Memory model: ack in the ack_lat-th cycle of mem_en (0 = never), plus injected stray acks
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'h0000;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ack = stray_ack;
         if (bus.mem_en) begin
            mm_cnt++;
            if (mm_cnt == ack_lat) begin
               bus.mem_ack = 1'b1;
               if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
               else bus.mem_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : 16'h0000;
            end
         end else begin
            mm_cnt = 0;
         end
      end
   end

   // Monitor: grant fields at mem_en rise, response fields at each rdy pulse
   initial begin
      logic prev_en;
      logic prev_rdy;
      int   en_cyc;
      exp_t e;
      prev_en  = 1'b0;
      prev_rdy = 1'b0;
      en_cyc   = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_en && !prev_en) begin
            en_cyc = 0;
            chk("grant_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               chk("grant_dma", 32'(bus.grant_dma), 32'(sb[0].dma));
               chk("mem_we", 32'(bus.mem_we), 32'(sb[0].we));
               chk("mem_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
               if (sb[0].we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(sb[0].wdata));
            end
         end
         if (bus.mem_en) en_cyc++;
         if (bus.cpu_rdy || bus.dma_rdy) begin
            chk("rdy_exclusive", 32'(bus.cpu_rdy & bus.dma_rdy), 32'd0);
            chk("rdy_one_cycle", 32'(prev_rdy), 32'd0);
            chk("mem_en_in_resp", 32'(bus.mem_en), 32'd0);
            chk("rdy_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("rdy_owner", 32'(bus.dma_rdy), 32'(e.dma));
               chk("rdata", 32'(e.dma ? bus.dma_rdata : bus.cpu_rdata), 32'(e.rdata));
               chk("xfer_cycles", 32'(en_cyc), 32'(e.lat));
               chk("timeout_err", 32'(bus.timeout_err), 32'(e.tmo));
            end
         end
         prev_en  = bus.mem_en;
         prev_rdy = bus.cpu_rdy | bus.dma_rdy;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired: observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int c1;
      rst = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 16'h0000; bus.dma_wdata = 16'h0000;
      mem_arr[16'h3000] = 16'h1234;
      mem_arr[16'h3001] = 16'h5678;
      mem_arr[16'h4000] = 16'h0A0A;
      for (int i = 0; i < 6; i++) mem_arr[16'h5000 + 16'(i)] = 16'hA000 + 16'(i);
      mem_arr[16'h6000] = 16'hD00D;
      mem_arr[16'h6001] = 16'hD11D;
      mem_arr[16'h8000] = 16'h8888;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'd0);
      chk("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 32'd0);
      chk("rst_flags", 32'({bus.cpu_rdy, bus.dma_rdy, bus.grant_dma, bus.timeout_err, bus.mem_we}), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Reset during XFER with no ack: everything drops at once, no rdy
      @(posedge clk);
      #1;
      ack_lat = 0;
      sb_push(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1, 1'b0);
      bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3000; bus.cpu_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_reset_mem_en", 32'(bus.mem_en), 32'd1);
      rst = 1'b0;
      #1;
      chk("reset_mem_en", 32'(bus.mem_en), 32'd0);
      chk("reset_cpu_rdy", 32'(bus.cpu_rdy), 32'd0);
      chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("reset_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      sb.delete();
      ack_lat = 1;
      sb_push(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      req_run(1'b0, 1, 1'b0, 16'h3000, 16'h0000, c0);

      // Plain CPU read: rdy seen on the third negedge after req (cycle 2)
      @(posedge clk);
      #1;
      sb_push(1'b0, 1'b0, 16'h3001, 16'h0000, 16'h5678, 1, 1'b0);
      req_run(1'b0, 1, 1'b0, 16'h3001, 16'h0000, c0);
      chk("read_latency", 32'(c0), 32'd3);

      // Tie: CPU read first, then DMA write; dma_rdata stays at reset value
      @(posedge clk);
      #1;
      sb_push(1'b0, 1'b0, 16'h4000, 16'h0000, 16'h0A0A, 1, 1'b0);
      sb_push(1'b1, 1'b1, 16'h4000, 16'hBEEF, 16'h0000, 1, 1'b0);
      fork
         req_run(1'b0, 1, 1'b0, 16'h4000, 16'h0000, c0);
         req_run(1'b1, 1, 1'b1, 16'h4000, 16'hBEEF, c1);
      join
      @(posedge clk);
      #1;
      sb_push(1'b0, 1'b0, 16'h4000, 16'h0000, 16'hBEEF, 1, 1'b0);
      req_run(1'b0, 1, 1'b0, 16'h4000, 16'h0000, c0);

      // Fairness: 4 CPU grants, DMA, then CPU wins the next tie because the streak cleared
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) sb_push(1'b0, 1'b0, 16'h5000 + 16'(i), 16'h0000, 16'hA000 + 16'(i), 1, 1'b0);
      sb_push(1'b1, 1'b0, 16'h6000, 16'h0000, 16'hD00D, 1, 1'b0);
      sb_push(1'b0, 1'b0, 16'h5004, 16'h0000, 16'hA004, 1, 1'b0);
      sb_push(1'b0, 1'b0, 16'h5005, 16'h0000, 16'hA005, 1, 1'b0);
      sb_push(1'b1, 1'b0, 16'h6001, 16'h0000, 16'hD11D, 1, 1'b0);
      fork
         req_run(1'b0, 6, 1'b0, 16'h5000, 16'h0000, c0);
         req_run(1'b1, 2, 1'b0, 16'h6000, 16'h0000, c1);
      join

      // Wait states: address held while cpu_addr moves
      @(posedge clk);
      #1;
      ack_lat = 5;
      sb_push(1'b0, 1'b0, 16'h8000, 16'h0000, 16'h8888, 5, 1'b0);
      fork
         req_run(1'b0, 1, 1'b0, 16'h8000, 16'h0000, c0);
         begin
            repeat (3) @(negedge clk);
            bus.cpu_addr = 16'h8FFF;
            @(negedge clk);
            chk("mem_addr_stable", 32'(bus.mem_addr), 32'h8000);
            chk("mem_en_held", 32'(bus.mem_en), 32'd1);
         end
      join
      ack_lat = 1;

      // Stray ack in IDLE does nothing
      @(negedge clk);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("stray_ack_mem_en", 32'(bus.mem_en), 32'd0);
      chk("stray_ack_rdy", 32'({bus.cpu_rdy, bus.dma_rdy}), 32'd0);

`ifdef LC3_MEM_ARB_TIMEOUT_EN
      // No ack: abort after 8 XFER cycles, rdata unchanged, later ack ignored
      @(posedge clk);
      #1;
      ack_lat = 0;
      sb_push(1'b0, 1'b0, 16'h9000, 16'h0000, 16'h0000, 8, 1'b1);
      req_run(1'b0, 1, 1'b0, 16'h9000, 16'h0000, c0);
      @(negedge clk);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("tmo_late_ack_mem_en", 32'(bus.mem_en), 32'd0);
      chk("tmo_late_ack_rdata", 32'(bus.cpu_rdata), 32'h8888);
      ack_lat = 1;
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
